adder_nibble_sequencer: RTL and testbench
=========================================

# adder_nibble_sequencer

Multi-cycle wide adder controller that sits directly upstream and downstream of the 4-bit adder stage (`adder_4bits` combined or `adder_4bits_pipeline`). It accepts two wide operands through a start/ready handshake and feeds them to the 4-bit adder one nibble at a time, LSB first. It collects each nibble's sum and carry after the adder's latency, applies the inter-nibble carry itself, and presents the wide result with a one-cycle `done` pulse.

## Interface
- `NIBBLES`, 4 — operand width in nibbles; 2..8 (default 16-bit operands).
- `ADDER_LATENCY`, 1 — edges between `adder_a/adder_b` applied and `adder_sum/adder_c` valid; 0 = combined adder, 1..3 = pipelined adder.
- `CLK` input 1 — single clock, rising edge.
- `RST` input 1 — reset, asynchronous, active-low.
- `start` input 1 — request; sampled only while `ready`=1.
- `op_a` input 4*NIBBLES — operand A, captured on the accepting edge.
- `op_b` input 4*NIBBLES — operand B, captured on the accepting edge.
- `ready` output 1 — high in IDLE only.
- `adder_a` output 4 — nibble of A to the adder.
- `adder_b` output 4 — nibble of B to the adder.
- `adder_sum` input 4 — adder sum.
- `adder_c` input 1 — adder carry.
- `result` output 4*NIBBLES — wide sum; held until the next accepted start.
- `carry_out` output 1 — carry out of the MSB nibble; held with `result`.
- `done` output 1 — one-cycle pulse: `result`/`carry_out` valid.

## Operation
- States:
  - IDLE: `ready`=1. `start`=1 on an edge captures `op_a`/`op_b` into shift registers, clears nibble index k, clears carry register `cin`, and moves to ISSUE.
  - ISSUE: drives nibble k, holds it stable, and counts wait cycles.
  - DONE: `done`=1 for exactly one cycle, then returns to IDLE.
- ISSUE wait and capture:
  - The wait counter runs 0..ADDER_LATENCY.
  - On the edge where counter = ADDER_LATENCY, capture the corrected nibble into `result[4k+3:4k]` and update `cin`.
  - Then either advance k and restart the counter, or, if k = NIBBLES-1, go to DONE.
- Carry correction (the adder has no carry-in):
  - nibble = `adder_sum` + `cin` (mod 16).
  - new `cin` = `adder_c` | (`adder_sum`==4'hF & `cin`).
  - `carry_out` = final `cin`.
- `adder_a`/`adder_b` are 0 in IDLE and DONE.
- `start` and operand changes outside IDLE are ignored. No queuing.
- `result` is overwritten nibble by nibble during a new operation. It is valid only when `done`=1 and afterwards until the next accept.
- Reset (any time, including mid-operation): state IDLE; `ready`=1; `done`=0; `adder_a`, `adder_b`, `result`, `carry_out`, `cin`, k and counter all 0. The aborted operation produces no `done`.

## Timing
- Accepting edge = E0. Nibble k is driven from E0+k·(ADDER_LATENCY+1) and captured at edge E0+(k+1)·(ADDER_LATENCY+1).
- `done` is high during the cycle following edge E0+NIBBLES·(ADDER_LATENCY+1).
- Defaults (NIBBLES=4, ADDER_LATENCY=1): 8 edges, `done` after the 8th edge, `ready` again after the 9th.
- Back-to-back throughput: one operation per NIBBLES·(ADDER_LATENCY+1)+2 cycles. `start` held high is accepted on the first IDLE edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `ADDER_NIBBLE_SEQ_OVF_EN`
  - Defined: adds output `overflow` (1 bit), the two's-complement signed overflow = (A_msb == B_msb) & (result_msb != A_msb). It is registered with `result`, valid with `done`, reset 0, and held like `result`.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- NIBBLES=4, L=1, reference pipelined adder: A=0x1234, B=0x4321 → `done` after 8 edges, `result`=0x5555, `carry_out`=0.
- A=0xFFFF, B=0x0001 (exercises F+cin correction on nibbles 1..3) → `result`=0x0000, `carry_out`=1.
- L=0, combined adder: A=0x00FF, B=0x0F01 → `done` after 4 edges, `result`=0x1000, `carry_out`=0.
- `start` pulsed with A=0xAAAA at edge 3 of a running operation on 0x1111+0x2222 → ignored; `result`=0x3333 and exactly one `done`.
- `RST` low at edge 4 of an operation → all outputs 0 and `ready`=1 immediately, no `done`. After release, 0x0001+0x0001 gives 0x0002.
- With `ADDER_NIBBLE_SEQ_OVF_EN`: 0x7FFF+0x0001 → `result`=0x8000, `overflow`=1. Then 0xFFFF+0x0001 → `overflow`=0.

Source files
------------

// File: rtl/adder_nibble_sequencer.sv
// Wide adder controller: feeds a 4-bit adder one nibble per step (LSB first), applies inter-nibble carry.
// Optional `ADDER_NIBBLE_SEQ_OVF_EN adds a registered signed-overflow output.
module adder_nibble_sequencer #(
    parameter int NIBBLES       = 4,
    parameter int ADDER_LATENCY = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 ready,
    output logic [3:0]           adder_a,
    output logic [3:0]           adder_b,
    input  logic [3:0]           adder_sum,
    input  logic                 adder_c,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
    output logic                 overflow,
`endif
    output logic                 done
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);
    localparam logic [1:0]    LAT    = 2'(ADDER_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [KW-1:0]   k_q, k_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            cin_q, cin_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [3:0]      adder_a_q, adder_a_d, adder_b_q, adder_b_d;
    logic [3:0]      nib;
    logic            cin_nxt;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
    logic            a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

    // The adder has no carry-in, so the stored carry is folded in here.
    assign nib     = adder_sum + {3'b000, cin_q};
    assign cin_nxt = adder_c | ((&adder_sum) & cin_q);

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        cin_d     = cin_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        adder_a_d = adder_a_q;
        adder_b_d = adder_b_q;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d    = op_a >> 4;
                    b_sh_d    = op_b >> 4;
                    adder_a_d = op_a[3:0];
                    adder_b_d = op_b[3:0];
                    k_d       = '0;
                    cnt_d     = '0;
                    cin_d     = 1'b0;
                    ready_d   = 1'b0;
                    state_d   = S_ISSUE;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
                    a_msb_d   = op_a[W-1];
                    b_msb_d   = op_b[W-1];
`endif
                end
            end
            S_ISSUE: begin
                if (cnt_q == LAT) begin
                    result_d[{k_q, 2'b00} +: 4] = nib;
                    cin_d = cin_nxt;
                    cnt_d = '0;
                    if (k_q == K_LAST) begin
                        cout_d    = cin_nxt;
                        adder_a_d = 4'h0;
                        adder_b_d = 4'h0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
                        ovf_d     = (a_msb_q == b_msb_q) & (nib[3] != a_msb_q);
`endif
                    end else begin
                        k_d       = k_q + KW'(1);
                        adder_a_d = a_sh_q[3:0];
                        adder_b_d = b_sh_q[3:0];
                        a_sh_d    = a_sh_q >> 4;
                        b_sh_d    = b_sh_q >> 4;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            cin_q     <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            adder_a_q <= 4'h0;
            adder_b_q <= 4'h0;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            cin_q     <= cin_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            adder_a_q <= adder_a_d;
            adder_b_q <= adder_b_d;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign adder_a   = adder_a_q;
    assign adder_b   = adder_b_q;
    assign result    = result_q;
    assign carry_out = cout_q;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// Bench: two sequencers (pipelined adder L=1, combined adder L=0) checked against plain wide addition.
module tb_adder_nibble_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] op_a, op_b;

    logic        rdy1, co1, dn1, c1;
    logic [3:0]  aa1, ab1, sum1;
    logic [15:0] res1;
    logic        rdy0, co0, dn0, c0;
    logic [3:0]  aa0, ab0, sum0;
    logic [15:0] res0;
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
    logic        ovf1, ovf0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference adders: one-stage pipelined and purely combinational.
    always @(posedge CLK) {c1, sum1} <= {1'b0, aa1} + {1'b0, ab1};
    assign {c0, sum0} = {1'b0, aa0} + {1'b0, ab0};

    adder_nibble_sequencer #(.NIBBLES(4), .ADDER_LATENCY(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(rdy1), .adder_a(aa1), .adder_b(ab1), .adder_sum(sum1), .adder_c(c1),
        .result(res1), .carry_out(co1),
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
        .overflow(ovf1),
`endif
        .done(dn1)
    );

    adder_nibble_sequencer #(.NIBBLES(4), .ADDER_LATENCY(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(rdy0), .adder_a(aa0), .adder_b(ab0), .adder_sum(sum0), .adder_c(c0),
        .result(res0), .carry_out(co0),
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
        .overflow(ovf0),
`endif
        .done(dn0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit disturb, input string tag);
        logic [16:0] exp;
        logic [16:0] r0, r1;
        logic        o0, o1, exp_ovf;
        int e0, d0cnt, d1cnt, d0lat, d1lat, w;
        exp     = {1'b0, a} + {1'b0, b};
        exp_ovf = (a[15] == b[15]) && (exp[15] != a[15]);
        d0cnt = 0; d1cnt = 0; d0lat = -1; d1lat = -1;
        r0 = '0; r1 = '0; o0 = 1'b0; o1 = 1'b0;
        w = 0;
        while (!(rdy0 && rdy1) && w < 30) begin
            @(negedge CLK);
            w++;
        end
        check({tag, "/idle_wait"}, {30'd0, rdy0, rdy1}, 32'd3);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge CLK);
        e0    = cyc;
        start = 1'b0;
        check({tag, "/ready_busy"}, {30'd0, rdy0, rdy1}, 32'd0);
        check({tag, "/nib0_a"}, {24'd0, aa1, aa0}, {24'd0, a[3:0], a[3:0]});
        check({tag, "/nib0_b"}, {24'd0, ab1, ab0}, {24'd0, b[3:0], b[3:0]});
        for (int j = 1; j <= 14; j++) begin
            if (disturb && j == 2) begin
                start = 1'b1;
                op_a  = 16'hAAAA;
                op_b  = 16'h5555;
            end else if (disturb && j == 3) begin
                start = 1'b0;
                op_a  = a;
                op_b  = b;
            end
            @(negedge CLK);
            if (dn0) begin
                d0cnt++;
                d0lat = cyc - e0;
                r0    = {co0, res0};
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
                o0    = ovf0;
`endif
            end
            if (dn1) begin
                d1cnt++;
                d1lat = cyc - e0;
                r1    = {co1, res1};
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
                o1    = ovf1;
`endif
            end
        end
        check({tag, "/L0_done_count"}, d0cnt, 1);
        check({tag, "/L0_latency"}, d0lat, 4);
        check({tag, "/L0_sum"}, {15'd0, r0}, {15'd0, exp});
        check({tag, "/L1_done_count"}, d1cnt, 1);
        check({tag, "/L1_latency"}, d1lat, 8);
        check({tag, "/L1_sum"}, {15'd0, r1}, {15'd0, exp});
        check({tag, "/L1_held"}, {15'd0, co1, res1}, {15'd0, exp});
        check({tag, "/idle_adder_in"}, {16'd0, aa1, ab1, aa0, ab0}, 32'd0);
`ifdef ADDER_NIBBLE_SEQ_OVF_EN
        check({tag, "/ovf"}, {30'd0, o1, o0}, {30'd0, exp_ovf, exp_ovf});
`else
        check({tag, "/ovf_absent"}, {30'd0, o1, o0}, 32'd0);
`endif
    endtask

    task automatic reset_mid_op();
        w_ready();
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst/ready", {30'd0, rdy1, rdy0}, 32'd3);
        check("rst/done", {30'd0, dn1, dn0}, 32'd0);
        check("rst/result", {res1, res0}, 32'd0);
        check("rst/carry", {30'd0, co1, co0}, 32'd0);
        check("rst/adder_in", {16'd0, aa1, ab1, aa0, ab0}, 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            if (j == 2) RST = 1'b1;
            check("rst/no_done", {30'd0, dn1, dn0}, 32'd0);
        end
    endtask

    task automatic w_ready();
        int w;
        w = 0;
        while (!(rdy0 && rdy1) && w < 30) begin
            @(negedge CLK);
            w++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin
        RST   = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge CLK);
        check("reset/ready", {30'd0, rdy1, rdy0}, 32'd3);
        check("reset/done", {30'd0, dn1, dn0}, 32'd0);
        check("reset/result", {res1, res0}, 32'd0);
        check("reset/carry", {30'd0, co1, co0}, 32'd0);
        check("reset/adder_in", {16'd0, aa1, ab1, aa0, ab0}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        run_op(16'h1234, 16'h4321, 1'b0, "d_1234_4321");
        run_op(16'hFFFF, 16'h0001, 1'b0, "d_FFFF_0001");
        run_op(16'h00FF, 16'h0F01, 1'b0, "d_00FF_0F01");
        run_op(16'h1111, 16'h2222, 1'b1, "d_ignored_start");
        run_op(16'h7FFF, 16'h0001, 1'b0, "d_7FFF_0001");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, "d_FFFF_FFFF");
        run_op(16'h8000, 16'h8000, 1'b0, "d_8000_8000");
        run_op(16'h0000, 16'h0000, 1'b0, "d_zero");

        reset_mid_op();
        run_op(16'h0001, 16'h0001, 1'b0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            run_op(ra, rb, (i % 5) == 0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
